// File: rtl/ram_input_pkg.sv
// Shared constants for the convolution input buffer: default geometry and sweep FSM encoding.
package ram_input_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 19;
  localparam int DEF_ADDR_W = 5;

  localparam logic ST_SWEEP = 1'b1;
  localparam logic ST_IDLE  = 1'b0;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SWEEP = ST_SWEEP
  } sweep_state_e;

endpackage

// File: rtl/ram_input_sweep_ctrl.sv
// Zero-sweep controller: walks every address once after reset or clear, holding busy meanwhile.
module ram_input_sweep_ctrl
  import ram_input_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  sweep_state_e      state;
  logic [ADDR_W-1:0] ptr;

  // Sweep FSM: clear always restarts from address 0, in either state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SWEEP;
      ptr   <= {ADDR_W{1'b0}};
      busy  <= 1'b1;
    end else if (clear) begin
      state <= S_SWEEP;
      ptr   <= {ADDR_W{1'b0}};
      busy  <= 1'b1;
    end else begin
      case (state)
        S_SWEEP: begin
          if (ptr == LAST_PTR) begin
            state <= S_IDLE;
            ptr   <= {ADDR_W{1'b0}};
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + PTR_ONE;
          end
        end
        S_IDLE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_SWEEP;
          ptr   <= {ADDR_W{1'b0}};
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign sweep_we   = (state == S_SWEEP);
  assign sweep_addr = ptr;

endmodule

// File: rtl/ram_input_param.sv
// Parametrised 1W/1R input buffer with self-clearing sweep and sticky out-of-range flag.
// Optional macro RAM_INPUT_BYPASS_EN: write-first on same-address collision (default read-first).
module ram_input_param
  import ram_input_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_oor
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  if ((2 ** ADDR_W) < DEPTH) begin : g_addr_w_check
    $error("ram_input_param: ADDR_W too small for DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_acc, rd_acc, wr_in, rd_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  ram_input_sweep_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Requests are only honoured when idle and not being cleared this cycle
  assign wr_acc = wr_en && !busy && !clear;
  assign rd_acc = rd_en && !busy && !clear;
  assign wr_in  = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_X);

  // Write-port mux: sweep owns the port while busy
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (sweep_we) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
    end else if (wr_acc && wr_in) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Array storage, no reset: contents are zeroed by the sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  // Read word selection, including optional same-address bypass
  always_comb begin
    rd_word = {DATA_W{1'b0}};
    if (rd_in) begin
`ifdef RAM_INPUT_BYPASS_EN
      if (wr_acc && wr_in && (wr_addr == rd_addr)) begin
        rd_word = wr_data;
      end else begin
        rd_word = mem[rd_addr[IDX_W-1:0]];
      end
`else
      rd_word = mem[rd_addr[IDX_W-1:0]];
`endif
    end else begin
      rd_word = {DATA_W{1'b0}};
    end
  end

  // Read register and sticky range-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= {DATA_W{1'b0}};
      rd_valid <= 1'b0;
      err_oor  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= rd_word;
      end
      if (clear) begin
        err_oor <= 1'b0;
      end else if ((wr_acc && !wr_in) || (rd_acc && !rd_in)) begin
        err_oor <= 1'b1;
      end
    end
  end

endmodule
